// File: rtl/rr_priority_arbiter.sv
// Round-robin arbiter with a rotating priority pointer, registered one-hot and
// encoded grants, and hold-time preemption when other requesters are waiting.
module rr_priority_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned IDW      = 3,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           gnt_new
);

    localparam int unsigned HCW       = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam bit          PREEMPT   = (MAX_HOLD != 0);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_d;
    logic [IDW-1:0]   ptr, ptr_d;
    logic [HCW-1:0]   hold_cnt, hold_d;
    logic [N-1:0]     gnt_d;
    logic [IDW-1:0]   id_d;
    logic             valid_d;
    logic             new_d;
    logic [N-1:0]     masked_c;
    logic [IDW-1:0]   pick_req_c;
    logic [IDW-1:0]   pick_masked_c;

    // First set bit of cand scanning last+1, last+2, ... modulo N.
    function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] cand,
                                               input logic [IDW-1:0] last);
        logic [IDW-1:0] idx;
        logic [IDW-1:0] sel;
        sel = '0;
        for (int k = N; k >= 1; k--) begin
            idx = last + IDW'(k);
            if (cand[idx]) sel = idx;
        end
        return sel;
    endfunction

    always_comb begin
        masked_c      = req & ~gnt;
        pick_req_c    = rr_pick(req, ptr);
        pick_masked_c = rr_pick(masked_c, ptr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= IDW'(N - 1);
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            gnt_new   <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            hold_cnt  <= hold_d;
            gnt       <= gnt_d;
            gnt_id    <= id_d;
            gnt_valid <= valid_d;
            gnt_new   <= new_d;
        end
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        hold_d  = hold_cnt;
        gnt_d   = gnt;
        id_d    = gnt_id;
        valid_d = gnt_valid;
        new_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    ptr_d   = pick_req_c;
                    id_d    = pick_req_c;
                    gnt_d   = N'(1) << pick_req_c;
                    valid_d = 1'b1;
                    new_d   = 1'b1;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!req[gnt_id]) begin
                    // Release: hand over without a bubble if anyone else waits.
                    if (|req) begin
                        ptr_d  = pick_req_c;
                        id_d   = pick_req_c;
                        gnt_d  = N'(1) << pick_req_c;
                        new_d  = 1'b1;
                        hold_d = '0;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        id_d    = '0;
                        valid_d = 1'b0;
                        hold_d  = '0;
                    end
                end else if (PREEMPT && hold_cnt == HCW'(HOLD_LAST) && |masked_c) begin
                    ptr_d  = pick_masked_c;
                    id_d   = pick_masked_c;
                    gnt_d  = N'(1) << pick_masked_c;
                    new_d  = 1'b1;
                    hold_d = '0;
                end else if (hold_cnt != HCW'(HOLD_LAST)) begin
                    hold_d = hold_cnt + HCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Bench for rr_priority_arbiter: two instances (hold limits 16 and 4) share one
// request stream and are compared every cycle against an owner/age reference model.
module tb_rr_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;

    logic [7:0] gnt16, gnt4;
    logic [2:0] id16, id4;
    logic       val16, val4, new16, new4;

    int n_asserts = 0;
    int n_fails   = 0;

    int m_owner [2];
    int m_last  [2];
    int m_age   [2];
    bit m_new   [2];
    int m_hold  [2] = '{16, 4};

    always #5 clk = ~clk;

    rr_priority_arbiter #(.N(8), .IDW(3), .MAX_HOLD(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt16), .gnt_id(id16), .gnt_valid(val16), .gnt_new(new16));

    rr_priority_arbiter #(.N(8), .IDW(3), .MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt4), .gnt_id(id4), .gnt_valid(val4), .gnt_new(new4));

    function automatic int pick(input logic [7:0] cand, input int last);
        for (int k = 1; k <= 8; k++) begin
            if (cand[(last + k) % 8]) return (last + k) % 8;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = -1;
            m_last[i]  = 7;
            m_age[i]   = 0;
            m_new[i]   = 1'b0;
        end
    endfunction

    function automatic void give(input int i, input int who);
        m_owner[i] = who;
        m_last[i]  = who;
        m_age[i]   = 0;
        m_new[i]   = 1'b1;
    endfunction

    // Outcome of one clock edge with request vector r, from the arbitration rules.
    function automatic void model_edge(input logic [7:0] r);
        logic [7:0] others;
        for (int i = 0; i < 2; i++) begin
            m_new[i] = 1'b0;
            if (m_owner[i] < 0) begin
                if (r != 0) give(i, pick(r, m_last[i]));
            end else if (!r[m_owner[i]]) begin
                if (r != 0) give(i, pick(r, m_last[i]));
                else m_owner[i] = -1;
            end else begin
                others = r;
                others[m_owner[i]] = 1'b0;
                if (m_hold[i] != 0 && m_age[i] >= m_hold[i] - 1 && others != 0)
                    give(i, pick(others, m_last[i]));
                else
                    m_age[i]++;
            end
        end
    endfunction

    task automatic chk1(input string tag, input int obs, input int exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        logic [7:0] g;
        logic [2:0] id;
        logic       v, nw;
        int         exp_g;
        for (int i = 0; i < 2; i++) begin
            g  = (i == 0) ? gnt16 : gnt4;
            id = (i == 0) ? id16  : id4;
            v  = (i == 0) ? val16 : val4;
            nw = (i == 0) ? new16 : new4;
            exp_g = (m_owner[i] >= 0) ? (1 << m_owner[i]) : 0;
            chk1($sformatf("gnt[h%0d]", m_hold[i]), int'(g), exp_g);
            chk1($sformatf("gnt_valid[h%0d]", m_hold[i]), int'(v), int'(m_owner[i] >= 0));
            chk1($sformatf("gnt_new[h%0d]", m_hold[i]), int'(nw), int'(m_new[i]));
            if (m_owner[i] >= 0)
                chk1($sformatf("gnt_id[h%0d]", m_hold[i]), int'(id), m_owner[i]);
        end
    endtask

    task automatic step(input logic [7:0] r);
        req = r;
        model_edge(r);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk1("async_rst_gnt16", int'(gnt16), 0);
        chk1("async_rst_val16", int'(val16), 0);
        chk1("async_rst_new16", int'(new16), 0);
        chk1("async_rst_gnt4", int'(gnt4), 0);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        chk1("reset_gnt_id", int'(id16), 0);
        rst_n = 1'b1;

        // Idle with no requests
        repeat (5) step(8'h00);

        // Two requesters, release handover without bubble, then idle
        step(8'h81);
        chk1("first_grant_0", int'(gnt16), 8'h01);
        step(8'h81);
        step(8'h80);
        chk1("handover_to_7", int'(gnt16), 8'h80);
        chk1("handover_new", int'(new16), 1);
        step(8'h00);
        chk1("release_idle", int'(val16), 0);

        // Wrap-around from pointer 6
        step(8'h40);
        step(8'h00);
        step(8'h05);
        chk1("wrap_to_0", int'(gnt16), 8'h01);
        step(8'h04);
        chk1("then_2", int'(id16), 2);
        step(8'h00);

        // Lone holder past the limit, then a competitor appears
        repeat (20) step(8'h08);
        chk1("no_rotation_alone", int'(gnt16), 8'h08);
        step(8'h0A);
        chk1("preempt_to_1", int'(gnt16), 8'h02);
        step(8'h00);
        step(8'h0A);
        chk1("grant_3", int'(id16), 3);
        for (int c = 1; c <= 16; c++) begin
            step(8'h0A);
            if (c == 15) chk1("hold_16_still_3", int'(id16), 3);
        end
        chk1("rotate_after_16", int'(id16), 1);
        step(8'h00);

        // All requesting: full rotation
        repeat (40) step(8'hFF);
        step(8'h00);

        // Async reset mid-grant on requester 5
        step(8'h20);
        chk1("grant_5", int'(id16), 5);
        async_reset();
        step(8'hFF);
        chk1("post_reset_0", int'(gnt16), 8'h01);
        step(8'h00);

        // Random traffic with occasional async resets
        for (int t = 0; t < 400; t++) begin
            logic [7:0] r;
            r = 8'($urandom);
            if ($urandom_range(3) == 0) r = r & 8'($urandom);
            if ($urandom_range(9) == 0) r = '0;
            step(r);
            if ($urandom_range(99) == 0) async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Arbitrates one shared resource among N requesters.
- Scans requests with a circular (rotating) priority encoder and issues a registered one-hot grant plus an encoded grant index.
- Holds the grant until the owner releases it or a hold-time limit expires while others wait.
- Sits in front of any shared datapath whose select is driven by an encoded index.

Parameters:
- N, 8, number of requesters (power of two, ≥2).
- IDW, 3, index width, equal to log2(N).
- MAX_HOLD, 16, maximum grant cycles before forced rotation when another requester is pending; 0 disables preemption.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector, level-sensitive, bit i = requester i.
- gnt  output  N  registered one-hot grant, all-zero when idle.
- gnt_id  output  IDW  encoded index of the granted requester; valid only when gnt_valid=1.
- gnt_valid  output  1  high while any grant is held.
- gnt_new  output  1  one-cycle pulse in the first cycle of each new grant, including back-to-back handovers.

Behaviour:
- Reset (asynchronous, immediate, including mid-grant):
  - gnt=0, gnt_id=0, gnt_valid=0, gnt_new=0.
  - state=IDLE, hold_cnt=0.
  - Last-grant pointer ptr=N-1, so requester 0 has top priority after reset.
- Circular pick: the first set bit of the candidate vector scanning ptr+1, ptr+2, … modulo N. Wrap from N-1 to 0 is required.
- States:
  - IDLE
  - GRANT
- IDLE:
  - req==0: stay; outputs stay zero.
  - req!=0: at the next edge, grant the circular pick of req. Registered, 1-cycle latency from req sampled to gnt.
  - On entering GRANT: gnt_valid=1, gnt_new=1, ptr=picked index, hold_cnt=0, next state GRANT.
- GRANT (cur=gnt_id), evaluated at each edge, first match wins:
  - a) req[cur]==0 (release):
    - If other req bits are set, hand over directly to the circular pick of req: gnt_new=1, ptr updated, hold_cnt=0, stay GRANT. No idle bubble.
    - Otherwise go to IDLE with gnt=0 and gnt_valid=0 on that edge.
  - b) MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and (req with bit cur masked)!=0:
    - Preempt: grant the circular pick of the masked vector.
    - gnt_new=1, ptr updated, hold_cnt=0.
  - c) Otherwise keep the grant; hold_cnt increments, saturating at MAX_HOLD-1.
- Once the hold limit is reached with no competitor, the grant persists. Preemption then occurs on the first edge at which any other request is seen.
- A release and an expired hold on the same edge are treated as release (rule a).
- The grant is never given to a requester whose req bit is 0 at the sampling edge.
- A requester dropping and reasserting req while not granted loses no priority. Priority depends only on ptr.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt==(1<<gnt_id) whenever gnt_valid=1.
  - gnt_new is never high when gnt_valid=0.
- Fairness: with all N requesting continuously and MAX_HOLD>0, each requester receives a grant within N*MAX_HOLD cycles.

Test Plan:
- Reset, then req=8'b0000_0000 for 5 cycles -> gnt=0, gnt_valid=0, gnt_new=0 throughout.
- req=8'b1000_0001 held -> one edge later gnt=8'b0000_0001, gnt_id=0, gnt_new pulses once. Drop req[0] -> next edge gnt=8'b1000_0000, gnt_id=7, gnt_new=1, no idle cycle. Drop req[7] -> gnt=0, gnt_valid=0.
- Wrap-around: ptr=6 (last grant to 6), req=8'b0000_0101 -> grant goes to 0, not 2. Next release -> grant to 2.
- Preemption with MAX_HOLD=16: req=8'b0000_1000 alone for 20 cycles -> grant held, no rotation. Assert req[1] at cycle 20 -> next edge gnt=8'b0000_0010. With req[1] continuously set from the grant to 3, rotation occurs after exactly 16 grant cycles.
- All 8 requesting continuously, MAX_HOLD=4 -> grant sequence 0,1,2,…,7,0 with each grant lasting 4 cycles and gnt_new pulsing at each change.
- Assert rst_n low mid-grant (gnt_id=5), asynchronously between edges -> gnt, gnt_valid, gnt_new drop to 0 immediately. After release with req=8'hFF, the first grant goes to requester 0.
